// File: rtl/ysyx_22040237_exu_mc.sv
// Multi-cycle execute unit: one-cycle RV64I ALU ops, jump-target add, iterative mul/div.
// Define YSYX_22040237_EXU_MDU_EN to build the shift-add multiplier / restoring divider.
module ysyx_22040237_exu_mc #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [XLEN-1:0]   in_op1,
  input  logic [XLEN-1:0]   in_op2,
  input  logic [ADDR_W-1:0] in_jop1,
  input  logic [ADDR_W-1:0] in_jop2,
  input  logic              in_ebreak,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rd_data,
  output logic [ADDR_W-1:0] out_jump_addr,
  output logic              out_ebreak,
  output logic              busy
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);

`ifdef YSYX_22040237_EXU_MDU_EN
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MULH  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(12);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_REM   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_REMU  = OP_W'(16);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`else
  typedef enum logic {S_IDLE, S_DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [XLEN-1:0]   rd_q, rd_nxt, alu_res;
  logic [ADDR_W-1:0] jump_q;
  logic              ebreak_q;
  logic              accept;
  logic [SHW-1:0]    shamt;

  assign in_ready      = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign out_valid     = (state == S_DONE);
  assign accept        = in_valid && in_ready;
  assign out_rd_data   = rd_q;
  assign out_jump_addr = jump_q;
  assign out_ebreak    = ebreak_q;
  assign shamt         = in_op2[SHW-1:0];

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_op1 + in_op2;
      OP_SUB:  alu_res = in_op1 - in_op2;
      OP_AND:  alu_res = in_op1 & in_op2;
      OP_OR:   alu_res = in_op1 | in_op2;
      OP_XOR:  alu_res = in_op1 ^ in_op2;
      OP_SLL:  alu_res = in_op1 << shamt;
      OP_SRL:  alu_res = in_op1 >> shamt;
      OP_SRA:  alu_res = $signed(in_op1) >>> shamt;
      OP_SLT:  alu_res = XLEN'($signed(in_op1) < $signed(in_op2));
      OP_SLTU: alu_res = XLEN'(in_op1 < in_op2);
      default: alu_res = '0;
    endcase
  end

`ifdef YSYX_22040237_EXU_MDU_EN
  logic              is_mul, is_div, sgn_op, a_neg, b_neg, neg_nxt, md_fast;
  logic [XLEN-1:0]   a_mag, b_mag, md_fast_res, md_res;
  logic [XLEN-1:0]   hi_q, lo_q, b_q, hi_step, lo_step;
  logic              mul_q, neg_q;
  logic [OP_W-1:0]   kind_q;
  logic [SHW-1:0]    cnt_q;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] prod;

  // Accept-side decode: magnitudes, result sign and the one-cycle divide corner cases.
  always_comb begin
    is_mul  = in_op inside {OP_MUL, OP_MULH, OP_MULHU};
    is_div  = in_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    sgn_op  = in_op inside {OP_MULH, OP_DIV, OP_REM};
    a_neg   = sgn_op && in_op1[XLEN-1];
    b_neg   = sgn_op && in_op2[XLEN-1];
    a_mag   = a_neg ? -in_op1 : in_op1;
    b_mag   = b_neg ? -in_op2 : in_op2;
    neg_nxt = (in_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    md_fast     = 1'b0;
    md_fast_res = '0;
    if (is_div && in_op2 == '0) begin
      md_fast     = 1'b1;
      md_fast_res = (in_op == OP_DIV || in_op == OP_DIVU) ? '1 : in_op1;
    end else if ((in_op == OP_DIV || in_op == OP_REM) && in_op1 == MOST_NEG && in_op2 == '1) begin
      md_fast     = 1'b1;
      md_fast_res = (in_op == OP_DIV) ? MOST_NEG : '0;
    end
  end

  // {hi,lo} is the product/multiplier pair for mul, remainder/quotient pair for div.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    if (mul_q) begin
      hi_step = sum[XLEN:1];
      lo_step = {sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_step = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end
    prod = neg_q ? -{hi_step, lo_step} : {hi_step, lo_step};
    case (kind_q)
      OP_MUL:            md_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHU: md_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   md_res = neg_q ? -lo_step : lo_step;
      default:           md_res = neg_q ? -hi_step : hi_step;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      kind_q <= '0;
      mul_q  <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      hi_q   <= '0;
      lo_q   <= is_mul ? b_mag : a_mag;
      b_q    <= is_mul ? a_mag : b_mag;
      kind_q <= in_op;
      mul_q  <= is_mul;
      neg_q  <= neg_nxt;
      cnt_q  <= '0;
    end else if (state == S_CALC) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    rd_nxt    = rd_q;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef YSYX_22040237_EXU_MDU_EN
          if ((is_mul || is_div) && !md_fast) begin
            state_nxt = S_CALC;
          end else begin
            state_nxt = S_DONE;
            rd_nxt    = (is_mul || is_div) ? md_fast_res : alu_res;
          end
`else
          state_nxt = S_DONE;
          rd_nxt    = alu_res;
`endif
        end
      end
`ifdef YSYX_22040237_EXU_MDU_EN
      S_CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_nxt = S_DONE;
          rd_nxt    = md_res;
        end
      end
`endif
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      rd_q     <= '0;
      jump_q   <= '0;
      ebreak_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_q  <= rd_nxt;
      if (accept) begin
        jump_q   <= in_jop1 + in_jop2;
        ebreak_q <= in_ebreak;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22040237_exu_mc.sv
// Bench for ysyx_22040237_exu_mc: directed vector table, corner sequences, random ops vs model.
module tb_ysyx_22040237_exu_mc;
`ifdef YSYX_22040237_EXU_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_ebreak = 1'b0;
  logic [4:0]  in_op = '0;
  logic [63:0] in_op1 = '0, in_op2 = '0;
  logic [31:0] in_jop1 = '0, in_jop2 = '0;
  logic        out_valid, out_ready = 1'b0, out_ebreak, busy;
  logic [63:0] out_rd_data;
  logic [31:0] out_jump_addr;

  always #5 clk = ~clk;

  ysyx_22040237_exu_mc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_op1(in_op1), .in_op2(in_op2), .in_jop1(in_jop1), .in_jop2(in_jop2),
    .in_ebreak(in_ebreak),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data),
    .out_jump_addr(out_jump_addr), .out_ebreak(out_ebreak), .busy(busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a, b;
    logic [31:0] j1, j2;
    logic        eb;
    int          hold;
    logic [63:0] rd;
    int          lat;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference results straight from the ISA definitions, using 128-bit and signed arithmetic.
  function automatic logic [63:0] ref_rd(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0]  sa, sb;
    logic        [127:0] p;
    int                  sh;
    sa = a;
    sb = b;
    sh = int'(b[5:0]);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << sh;
      5'd6:  return a >> sh;
      5'd7:  return sa >>> sh;
      5'd8:  return (sa < sb) ? 64'd1 : 64'd0;
      5'd9:  return (a < b) ? 64'd1 : 64'd0;
      default: ;
    endcase
    if (!MDU || op > 5'd16) return 64'd0;
    case (op)
      5'd10: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      5'd11: begin
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        return p[127:64];
      end
      5'd12: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      5'd13: begin
        if (b == 0) return ONES;
        if (a == MIN64 && b == ONES) return MIN64;
        return sa / sb;
      end
      5'd14: return (b == 0) ? ONES : a / b;
      5'd15: begin
        if (b == 0) return a;
        if (a == MIN64 && b == ONES) return 64'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    if (!MDU || op < 5'd10 || op > 5'd16) return 1;
    if (op >= 5'd13 && b == 0) return 1;
    if ((op == 5'd13 || op == 5'd15) && a == MIN64 && b == ONES) return 1;
    return 65;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    int          lat;
    logic [31:0] jexp;
    jexp = v.j1 + v.j2;
    @(negedge clk);
    check({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_op     = v.op;
    in_op1    = v.a;
    in_op2    = v.b;
    in_jop1   = v.j1;
    in_jop2   = v.j2;
    in_ebreak = v.eb;
    out_ready = (v.hold == 0);
    @(posedge clk);
    #1;
    // Scramble inputs so only the values captured at accept can produce the right answer.
    in_valid  = 1'b0;
    in_op1    = {$urandom, $urandom};
    in_op2    = {$urandom, $urandom};
    in_jop1   = $urandom;
    in_jop2   = $urandom;
    in_ebreak = ~v.eb;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    if (!out_valid) return;
    check({tag, " rd"}, out_rd_data, v.rd);
    check({tag, " jump"}, 64'(out_jump_addr), 64'(jexp));
    check({tag, " ebreak"}, 64'(out_ebreak), 64'(v.eb));
    check({tag, " in_ready while valid"}, 64'(in_ready), 64'd0);
    for (int k = 0; k < v.hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, " held valid"}, 64'(out_valid), 64'd1);
      check({tag, " held rd"}, out_rd_data, v.rd);
      check({tag, " held in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " valid drop"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready back"}, 64'(in_ready), 64'd1);
    check({tag, " busy clear"}, 64'(busy), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{5'd0,  ONES, 64'd1, 32'h8000_0000, 32'd4, 1'b0, 0, 64'd0, 1};
    vecs[1]  = '{5'd10, 64'h1_0000_0000, 64'h1_0000_0000, 32'h100, 32'h4, 1'b0, 0,
                 64'd0, MDU ? 65 : 1};
    vecs[2]  = '{5'd12, 64'h1_0000_0000, 64'h1_0000_0000, 32'h200, 32'h8, 1'b1, 1,
                 MDU ? 64'd1 : 64'd0, MDU ? 65 : 1};
    vecs[3]  = '{5'd13, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32'h10, 32'h20, 1'b0, 0,
                 MDU ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0, MDU ? 65 : 1};
    vecs[4]  = '{5'd15, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32'h0, 32'h0, 1'b0, 2,
                 MDU ? ONES : 64'd0, MDU ? 65 : 1};
    vecs[5]  = '{5'd14, 64'd5, 64'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, MDU ? ONES : 64'd0, 1};
    vecs[6]  = '{5'd13, MIN64, ONES, 32'h1234, 32'h1, 1'b0, 0, MDU ? MIN64 : 64'd0, 1};
    vecs[7]  = '{5'd15, MIN64, ONES, 32'h1234, 32'h2, 1'b1, 0, 64'd0, 1};
    vecs[8]  = '{5'd7,  MIN64, 64'h43, 32'h4000, 32'h4, 1'b0, 5, 64'hF000_0000_0000_0000, 1};
    vecs[9]  = '{5'd8,  ONES, 64'd1, 32'h0, 32'h8, 1'b0, 0, 64'd1, 1};
    vecs[10] = '{5'd9,  ONES, 64'd1, 32'h0, 32'hC, 1'b1, 0, 64'd0, 1};
    vecs[11] = '{5'd1,  64'd0, 64'd1, 32'h7FFF_FFFF, 32'd1, 1'b0, 0, ONES, 1};
    vecs[12] = '{5'd5,  64'd1, 64'h7F, 32'h0, 32'h0, 1'b0, 1, MIN64, 1};
    vecs[13] = '{5'd20, ONES, ONES, 32'h44, 32'h4, 1'b1, 0, 64'd0, 1};
    vecs[14] = '{5'd11, MIN64, 64'd2, 32'h0, 32'h10, 1'b0, 0, MDU ? ONES : 64'd0, MDU ? 65 : 1};
    vecs[15] = '{5'd16, 64'd7, 64'd0, 32'h0, 32'h14, 1'b0, 0, MDU ? 64'd7 : 64'd0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset rd", out_rd_data, 64'd0);
    check("reset jump", 64'(out_jump_addr), 64'd0);
    check("reset ebreak", 64'(out_ebreak), 64'd0);

    for (int i = 0; i < 16; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Idle with in_valid low: nothing may move.
    repeat (4) @(posedge clk);
    #1;
    check("idle valid", 64'(out_valid), 64'd0);
    check("idle rd hold", out_rd_data, vecs[15].rd);
    check("idle busy", 64'(busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.op = (i % 2 == 0) ? 5'($urandom_range(10, 16)) : 5'($urandom_range(0, 31));
      v.a  = {$urandom, $urandom};
      v.b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: v.b = 64'd0;
        1: v.b = 64'($urandom_range(1, 9));
        2: begin v.a = MIN64; v.b = ONES; end
        3: v.a = 64'($urandom);
        default: ;
      endcase
      v.j1   = $urandom;
      v.j2   = $urandom;
      v.eb   = 1'($urandom_range(0, 1));
      v.hold = $urandom_range(0, 2);
      v.rd   = ref_rd(v.op, v.a, v.b);
      v.lat  = ref_lat(v.op, v.a, v.b);
      do_op(v, $sformatf("rand%0d op%0d", i, v.op));
    end

    // Reset mid-DIV: put a non-zero result in the register first so the clear is visible.
    do_op('{5'd3, 64'hF0, 64'h0F, 32'h0, 32'h0, 1'b0, 0, 64'hFF, 1}, "pre-abort OR");
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = 5'd13;
    in_op1    = 64'd100;
    in_op2    = 64'd3;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort busy mid-op", 64'(busy), 64'd1);
    check("abort valid mid-op", 64'(out_valid), MDU ? 64'd0 : 64'd1);
    rst = 1'b0;
    #2;
    check("abort async valid", 64'(out_valid), 64'd0);
    check("abort async busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort rd", out_rd_data, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
